mem_access_unit: RTL

Initiator-side load/store engine that sits between the core's memory pipeline stage and the simulation memory responder. It accepts one access at a time from the pipeline over a valid/ready handshake and drives a single-cycle request onto the memory request bus. It then waits a fixed response latency, captures the response code and read data, sign- or zero-extends loads, and returns a one-cycle completion pulse with a fault flag.

---
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator between the core's
// memory stage and the memory responder. One access at a time: present a
// one-cycle request, wait a fixed response latency, sample the response,
// extend load data and pulse o_done with the response code and fault flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a new access (o_ready high once out of reset)
// ST_REQ  | request fields on the o_req_* bus for exactly one cycle
// ST_WAIT | counting down the response latency, sample at terminal count
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int MEM_COUNT_W = 2,
  parameter int MEM_CODE_W  = 3,
  parameter int RES_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [WORD_W-1:0]      i_wr_data,
  input  logic                   i_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_count,
  input  logic                   i_signed,
  output logic                   o_done,
  output logic [WORD_W-1:0]      o_rd_data,
  output logic [MEM_CODE_W-1:0]  o_code,
  output logic                   o_fault,
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic                   o_req_wr_en,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code
);

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = MEM_COUNT_W'(0);
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = MEM_COUNT_W'(1);
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = MEM_COUNT_W'(2);
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = MEM_COUNT_W'(3);

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ          = MEM_CODE_W'(1);
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE         = MEM_CODE_W'(2);
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = MEM_CODE_W'(3);
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = MEM_CODE_W'(4);
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID       = MEM_CODE_W'(5);

  // Counter reload value; the counter reaches 0 on the sampling edge.
  localparam logic [3:0] LAT_LOAD = 4'(RES_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t                 state;
  logic [3:0]             lat_cnt;
  // Private copy of the access kind: o_req_* is cleared after ST_REQ but the
  // completion still needs size, direction and signedness.
  logic [MEM_COUNT_W-1:0] acc_count;
  logic                   acc_wr;
  logic                   acc_signed;

  logic [WORD_W-1:0]      ext_data;
  logic [MEM_CODE_W-1:0]  exp_code;
  logic                   res_fault;

  // Extend the responder's low-justified load data to a full word.
  always_comb begin
    ext_data = '0;
    case (acc_count)
      MEM_COUNT_BYTE: ext_data = acc_signed ? {{24{i_res_rd_data[7]}}, i_res_rd_data[7:0]}
                                            : {24'b0, i_res_rd_data[7:0]};
      MEM_COUNT_HALF: ext_data = acc_signed ? {{16{i_res_rd_data[15]}}, i_res_rd_data[15:0]}
                                            : {16'b0, i_res_rd_data[15:0]};
      MEM_COUNT_WORD: ext_data = i_res_rd_data;
      default:        ext_data = '0;
    endcase
  end

  // Anything other than the direction-matching code counts as a fault.
  always_comb begin
    exp_code  = acc_wr ? MEM_CODE_WRITE : MEM_CODE_READ;
    res_fault = (i_res_code != exp_code);
  end

  // Access sequencer with registered handshake, request bus and completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      o_ready       <= 1'b0;
      o_done        <= 1'b0;
      o_rd_data     <= '0;
      o_code        <= '0;
      o_fault       <= 1'b0;
      o_req_addr    <= '0;
      o_req_wr_data <= '0;
      o_req_wr_en   <= 1'b0;
      o_req_count   <= MEM_COUNT_NONE;
      lat_cnt       <= '0;
      acc_count     <= MEM_COUNT_NONE;
      acc_wr        <= 1'b0;
      acc_signed    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_ready <= 1'b1;
          if (o_ready && i_valid) begin
            if (i_count == MEM_COUNT_NONE) begin
              // Nothing to fetch: complete immediately as an invalid access.
              o_done    <= 1'b1;
              o_code    <= MEM_CODE_INVALID;
              o_fault   <= 1'b1;
              o_rd_data <= '0;
            end else begin
              o_ready       <= 1'b0;
              o_req_addr    <= i_addr;
              o_req_wr_data <= i_wr_data;
              o_req_wr_en   <= i_wr_en;
              o_req_count   <= i_count;
              acc_count     <= i_count;
              acc_wr        <= i_wr_en;
              acc_signed    <= i_signed;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          o_req_addr    <= '0;
          o_req_wr_data <= '0;
          o_req_wr_en   <= 1'b0;
          o_req_count   <= MEM_COUNT_NONE;
          lat_cnt       <= LAT_LOAD;
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            o_done    <= 1'b1;
            o_code    <= i_res_code;
            o_fault   <= res_fault;
            o_rd_data <= (res_fault || acc_wr) ? '0 : ext_data;
            o_ready   <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          o_ready <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
